// File: rtl/router_pkt_gen.sv
// Packet generator feeding the 3-port router: buffers payload words and emits
// header, length, payload and parity back-to-back, stalling only on router busy.
module router_pkt_gen #(
    parameter int DW    = 3,
    parameter int DEPTH = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_addr,
    input  logic [2:0]    cmd_len,
    input  logic          pay_valid,
    output logic          pay_ready,
    input  logic [DW-1:0] pay_data,
    input  logic          busy,
    output logic [DW-1:0] data_out,
    output logic          pkt_valid,
    output logic          pkt_done,
    output logic          cmd_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {IDLE, HDR, LEN, PAY, PAR} state_t;

    state_t          state_q;
    logic [DW-1:0]   mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q, wr_nxt, rd_nxt;
    logic [CW-1:0]   count_q;
    logic [1:0]      addr_q;
    logic [2:0]      len_q, rem_q;
    logic [DW-1:0]   data_out_q, par_q;
    logic            pkt_valid_q, pkt_done_q, cmd_err_q;
    logic            push, pop, cmd_illegal, cmd_fits;

    assign cmd_illegal = (cmd_addr == 2'd3) || (cmd_len == 3'd0);
    assign cmd_fits    = count_q >= CW'(cmd_len);
    assign cmd_ready   = (state_q == IDLE) && cmd_valid && (cmd_illegal || cmd_fits);
    assign pay_ready   = count_q < CW'(DEPTH);

    assign push   = pay_valid && pay_ready;
    assign pop    = (state_q == PAY) && !busy;
    assign wr_nxt = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    assign rd_nxt = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;

    assign data_out  = data_out_q;
    assign pkt_valid = pkt_valid_q;
    assign pkt_done  = pkt_done_q;
    assign cmd_err   = cmd_err_q;

    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= pay_data;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_nxt;
            if (pop)  rd_ptr_q <= rd_nxt;
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    // data_out_q always holds the word of the current state; each unstalled
    // edge folds that word into the parity and loads the next one.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            rem_q       <= '0;
            par_q       <= '0;
            data_out_q  <= '0;
            pkt_valid_q <= 1'b0;
            pkt_done_q  <= 1'b0;
            cmd_err_q   <= 1'b0;
        end else begin
            pkt_done_q <= 1'b0;
            cmd_err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_valid && cmd_illegal) begin
                        cmd_err_q <= 1'b1;
                    end else if (cmd_valid && cmd_fits) begin
                        addr_q      <= cmd_addr;
                        len_q       <= cmd_len;
                        par_q       <= '0;
                        data_out_q  <= DW'(cmd_addr);
                        pkt_valid_q <= 1'b1;
                        state_q     <= HDR;
                    end
                end
                HDR: if (!busy) begin
                    par_q      <= par_q ^ data_out_q;
                    data_out_q <= DW'(len_q);
                    state_q    <= LEN;
                end
                LEN: if (!busy) begin
                    par_q      <= par_q ^ data_out_q;
                    data_out_q <= mem_q[rd_ptr_q];
                    rem_q      <= len_q;
                    state_q    <= PAY;
                end
                PAY: if (!busy) begin
                    par_q <= par_q ^ data_out_q;
                    if (rem_q == 3'd1) begin
                        data_out_q  <= par_q ^ data_out_q;
                        pkt_valid_q <= 1'b0;
                        state_q     <= PAR;
                    end else begin
                        rem_q      <= rem_q - 3'd1;
                        data_out_q <= mem_q[rd_nxt];
                    end
                end
                PAR: if (!busy) begin
                    data_out_q <= '0;
                    pkt_done_q <= 1'b1;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    logic unused_addr;
    assign unused_addr = ^addr_q;
endmodule

// File: tb/tb_router_pkt_gen.sv
// Directed bench for router_pkt_gen: framing, stalls, command gating, FIFO limits.
module tb_router_pkt_gen;
    logic       clock, reset;
    logic       cmd_valid, cmd_ready;
    logic [1:0] cmd_addr;
    logic [2:0] cmd_len;
    logic       pay_valid, pay_ready;
    logic [2:0] pay_data;
    logic       busy;
    logic [2:0] data_out;
    logic       pkt_valid, pkt_done, cmd_err;

    int pass_cnt = 0;
    int total_cnt = 0;

    router_pkt_gen #(.DW(3), .DEPTH(8)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .pay_valid(pay_valid), .pay_ready(pay_ready), .pay_data(pay_data),
        .busy(busy), .data_out(data_out), .pkt_valid(pkt_valid),
        .pkt_done(pkt_done), .cmd_err(cmd_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic push(input logic [2:0] d);
        pay_valid = 1'b1;
        pay_data  = d;
        @(negedge clock);
        pay_valid = 1'b0;
    endtask

    task automatic test_reset;
        total_cnt++;
        if ({data_out, pkt_valid, pkt_done, cmd_err} !== 6'd0)
            $display("FAIL reset_outputs: got %b exp 000000", {data_out, pkt_valid, pkt_done, cmd_err});
        else pass_cnt++;
        total_cnt++;
        if ({pay_ready, cmd_ready} !== 2'b10)
            $display("FAIL reset_ready: got %b exp 10", {pay_ready, cmd_ready});
        else pass_cnt++;
        total_cnt++;
        if (dut.count_q !== 4'd0) $display("FAIL reset_count: got %0d exp 0", dut.count_q);
        else pass_cnt++;
    endtask

    task automatic test_basic;
        int ed[6] = '{1, 3, 5, 2, 7, 2};
        int ev[6] = '{1, 1, 1, 1, 1, 0};
        push(3'd5); push(3'd2); push(3'd7);
        cmd_valid = 1'b1; cmd_addr = 2'd1; cmd_len = 3'd3;
        #1;
        total_cnt++;
        if (cmd_ready !== 1'b1) $display("FAIL basic_cmd_ready: got %b exp 1", cmd_ready);
        else pass_cnt++;
        @(negedge clock);
        cmd_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            total_cnt++;
            if ({pkt_valid, data_out} !== {1'(ev[i]), 3'(ed[i])})
                $display("FAIL basic_word%0d: got v=%b d=%0d exp v=%0d d=%0d", i, pkt_valid, data_out, ev[i], ed[i]);
            else pass_cnt++;
            @(negedge clock);
        end
        total_cnt++;
        if ({pkt_done, pkt_valid, data_out, dut.count_q} !== {1'b1, 1'b0, 3'd0, 4'd0})
            $display("FAIL basic_done: got done=%b v=%b d=%0d cnt=%0d exp 1 0 0 0", pkt_done, pkt_valid, data_out, dut.count_q);
        else pass_cnt++;
        @(negedge clock);
        total_cnt++;
        if (pkt_done !== 1'b0) $display("FAIL basic_done_pulse: got %b exp 0", pkt_done);
        else pass_cnt++;
    endtask

    task automatic test_busy_stall;
        int ed[8] = '{1, 3, 5, 2, 2, 2, 7, 2};
        int ev[8] = '{1, 1, 1, 1, 1, 1, 1, 0};
        int eb[8] = '{0, 0, 0, 1, 1, 0, 0, 0};
        push(3'd5); push(3'd2); push(3'd7);
        cmd_valid = 1'b1; cmd_addr = 2'd1; cmd_len = 3'd3;
        @(negedge clock);
        cmd_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            total_cnt++;
            if ({pkt_valid, data_out} !== {1'(ev[i]), 3'(ed[i])})
                $display("FAIL busy_word%0d: got v=%b d=%0d exp v=%0d d=%0d", i, pkt_valid, data_out, ev[i], ed[i]);
            else pass_cnt++;
            busy = 1'(eb[i]);
            @(negedge clock);
        end
        total_cnt++;
        if ({pkt_done, dut.count_q} !== {1'b1, 4'd0})
            $display("FAIL busy_done: got done=%b cnt=%0d exp 1 0", pkt_done, dut.count_q);
        else pass_cnt++;
    endtask

    task automatic test_short_payload;
        int ed[7] = '{2, 4, 3, 4, 6, 1, 6};
        int ev[7] = '{1, 1, 1, 1, 1, 1, 0};
        @(negedge clock);
        push(3'd3); push(3'd4);
        cmd_valid = 1'b1; cmd_addr = 2'd2; cmd_len = 3'd4;
        #1;
        total_cnt++;
        if (cmd_ready !== 1'b0) $display("FAIL short_ready_cnt2: got %b exp 0", cmd_ready);
        else pass_cnt++;
        pay_valid = 1'b1; pay_data = 3'd6;
        @(negedge clock);
        total_cnt++;
        if (cmd_ready !== 1'b0) $display("FAIL short_ready_cnt3: got %b exp 0", cmd_ready);
        else pass_cnt++;
        pay_data = 3'd1;
        @(negedge clock);
        pay_valid = 1'b0;
        total_cnt++;
        if (cmd_ready !== 1'b1) $display("FAIL short_ready_cnt4: got %b exp 1", cmd_ready);
        else pass_cnt++;
        @(negedge clock);
        cmd_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            total_cnt++;
            if ({pkt_valid, data_out} !== {1'(ev[i]), 3'(ed[i])})
                $display("FAIL short_word%0d: got v=%b d=%0d exp v=%0d d=%0d", i, pkt_valid, data_out, ev[i], ed[i]);
            else pass_cnt++;
            @(negedge clock);
        end
        total_cnt++;
        if (pkt_done !== 1'b1) $display("FAIL short_done: got %b exp 1", pkt_done);
        else pass_cnt++;
    endtask

    task automatic test_illegal;
        logic [1:0] ia[2] = '{2'd3, 2'd0};
        logic [2:0] il[2] = '{3'd2, 3'd0};
        @(negedge clock);
        push(3'd5);
        for (int i = 0; i < 2; i++) begin
            cmd_valid = 1'b1; cmd_addr = ia[i]; cmd_len = il[i];
            #1;
            total_cnt++;
            if (cmd_ready !== 1'b1) $display("FAIL illegal%0d_ready: got %b exp 1", i, cmd_ready);
            else pass_cnt++;
            @(negedge clock);
            cmd_valid = 1'b0;
            total_cnt++;
            if ({cmd_err, pkt_valid, dut.count_q} !== {1'b1, 1'b0, 4'd1})
                $display("FAIL illegal%0d_err: got err=%b v=%b cnt=%0d exp 1 0 1", i, cmd_err, pkt_valid, dut.count_q);
            else pass_cnt++;
            @(negedge clock);
            total_cnt++;
            if ({cmd_err, pkt_valid} !== 2'b00)
                $display("FAIL illegal%0d_pulse: got err=%b v=%b exp 0 0", i, cmd_err, pkt_valid);
            else pass_cnt++;
        end
    endtask

    task automatic test_fifo_limits;
        int ed[5] = '{0, 2, 0, 1, 3};
        int ev[5] = '{1, 1, 1, 1, 0};
        #2 reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) push(3'(i));
        total_cnt++;
        if ({pay_ready, dut.count_q} !== {1'b0, 4'd8})
            $display("FAIL fifo_full: got rdy=%b cnt=%0d exp 0 8", pay_ready, dut.count_q);
        else pass_cnt++;
        push(3'd5);
        total_cnt++;
        if (dut.count_q !== 4'd8) $display("FAIL fifo_drop: got %0d exp 8", dut.count_q);
        else pass_cnt++;
        cmd_valid = 1'b1; cmd_addr = 2'd0; cmd_len = 3'd2;
        @(negedge clock);
        cmd_valid = 1'b0;
        // Push alongside the second payload pop; count must hold at 7.
        for (int i = 0; i < 5; i++) begin
            total_cnt++;
            if ({pkt_valid, data_out} !== {1'(ev[i]), 3'(ed[i])})
                $display("FAIL fifo_word%0d: got v=%b d=%0d exp v=%0d d=%0d", i, pkt_valid, data_out, ev[i], ed[i]);
            else pass_cnt++;
            pay_valid = (i == 3); pay_data = 3'd6;
            @(negedge clock);
        end
        pay_valid = 1'b0;
        total_cnt++;
        if (dut.count_q !== 4'd7) $display("FAIL fifo_push_pop: got %0d exp 7", dut.count_q);
        else pass_cnt++;
        cmd_valid = 1'b1; cmd_addr = 2'd1; cmd_len = 3'd3;
        @(negedge clock);
        cmd_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        total_cnt++;
        if ({pkt_valid, data_out} !== {1'b1, 3'd2})
            $display("FAIL rst_pre_pay: got v=%b d=%0d exp v=1 d=2", pkt_valid, data_out);
        else pass_cnt++;
        #2 reset = 1'b1;
        #1;
        total_cnt++;
        if ({pkt_valid, data_out, dut.count_q, pay_ready} !== {1'b0, 3'd0, 4'd0, 1'b1})
            $display("FAIL rst_mid_pay: got v=%b d=%0d cnt=%0d rdy=%b exp 0 0 0 1", pkt_valid, data_out, dut.count_q, pay_ready);
        else pass_cnt++;
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
        pay_valid = 1'b0; pay_data = '0; busy = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        test_reset;
        test_basic;
        test_busy_stall;
        test_short_payload;
        test_illegal;
        test_fifo_limits;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
